// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and constants for the LFSR generator.
//   fsm_state_t : controller states (IDLE / RUN / STALL)
//   lfsr_mode_t : feedback structure (Fibonacci / Galois)
//   TAPS_n      : default maximal-length tap masks for common widths
package lfsr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } fsm_state_t;

   typedef enum logic {
      MODE_FIB = 1'b0,
      MODE_GAL = 1'b1
   } lfsr_mode_t;

   localparam logic [3:0]  TAPS_4  = 4'b1100;
   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [15:0] TAPS_16 = 16'hB400;
   localparam logic [31:0] TAPS_32 = 32'hA300_0000;

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: combinational single-step of the LFSR.
//   state      : current register value
//   mode       : Fibonacci or Galois feedback
//   next_state : register value after one step
//   out_bit    : bit emitted by this step (taken before the shift)
module lfsr_step
   import lfsr_pkg::*;
#(
   parameter int unsigned          WIDTH = 16,
   parameter logic [WIDTH-1:0]     TAPS  = WIDTH'(TAPS_16)
) (
   input  logic [WIDTH-1:0] state,
   input  lfsr_mode_t       mode,
   output logic [WIDTH-1:0] next_state,
   output logic             out_bit
);

   always_comb begin
      if (mode == MODE_GAL) begin
         next_state = (state >> 1) ^ (state[0] ? TAPS : '0);
         out_bit    = state[0];
      end else begin
         next_state = {state[WIDTH-2:0], ^(state & TAPS)};
         out_bit    = state[WIDTH-1];
      end
   end

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: seeded Fibonacci/Galois LFSR with packed word output,
// valid/ready back-pressure and period measurement.
//   clk_in     : clock, rising edge
//   rst_n_in   : asynchronous active-low reset
//   seed_in    : seed, sampled on load_in (zero is replaced by 1)
//   mode_in    : 0 = Fibonacci, 1 = Galois, sampled on load_in
//   load_in    : load seed/mode and restart; highest priority
//   en_in      : step enable; when low everything holds
//   ready_in   : downstream accepts data_out
//   q_out      : current LFSR state
//   data_out   : last completed word, first generated bit in the MSB
//   valid_out  : data_out holds an unconsumed word
//   wrap_out   : one-cycle pulse when the state returns to the seed
//   period_out : step count of the last completed period
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_16),
   parameter int unsigned      OUT_W = 8
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             mode_in,
   input  logic             load_in,
   input  logic             en_in,
   input  logic             ready_in,
   output logic [WIDTH-1:0] q_out,
   output logic [OUT_W-1:0] data_out,
   output logic             valid_out,
   output logic             wrap_out,
   output logic [WIDTH-1:0] period_out
);

   localparam int unsigned CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

   if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_gen: WIDTH must be in 3..32");
   end
   if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
      $error("lfsr_gen: TAPS[WIDTH-1] must be 1");
   end
   if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_outw
      $error("lfsr_gen: OUT_W must be in 1..WIDTH");
   end

   fsm_state_t       fsm_q, fsm_d;
   lfsr_mode_t       mode_q, mode_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [OUT_W-1:0] shreg_q, shreg_d;
   logic [OUT_W-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             wrap_q, wrap_d;

   logic [WIDTH-1:0] step_next;
   logic             step_bit;
   logic [WIDTH-1:0] seed_fix;
   logic [OUT_W-1:0] shifted;
   logic             do_step;
   logic             word_done;
   logic             handshake;

   lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_step (
      .state      (lfsr_q),
      .mode       (mode_q),
      .next_state (step_next),
      .out_bit    (step_bit)
   );

   assign seed_fix  = (seed_in == '0) ? WIDTH'(1) : seed_in;
   // Truncating {shreg, bit} to OUT_W bits is a left shift with the new bit in the LSB.
   assign shifted   = OUT_W'({shreg_q, step_bit});
   assign do_step   = (fsm_q == RUN) && en_in && !load_in && !(valid_q && !ready_in);
   assign word_done = do_step && (bit_cnt_q == CW'(OUT_W - 1));
   assign handshake = en_in && valid_q && ready_in;

   always_comb begin
      fsm_d      = fsm_q;
      mode_d     = mode_q;
      lfsr_d     = lfsr_q;
      seed_d     = seed_q;
      step_cnt_d = step_cnt_q;
      period_d   = period_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      data_d     = data_q;
      valid_d    = valid_q;
      wrap_d     = 1'b0;

      if (load_in) begin
         lfsr_d     = seed_fix;
         seed_d     = seed_fix;
         mode_d     = lfsr_mode_t'(mode_in);
         step_cnt_d = '0;
         bit_cnt_d  = '0;
         shreg_d    = '0;
         valid_d    = 1'b0;
         fsm_d      = RUN;
      end else if (en_in && fsm_q != IDLE) begin
         if (do_step) begin
            lfsr_d  = step_next;
            shreg_d = shifted;
            if (word_done) begin
               data_d    = shifted;
               bit_cnt_d = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
            end
            if (step_next == seed_q) begin
               wrap_d     = 1'b1;
               period_d   = step_cnt_q + WIDTH'(1);
               step_cnt_d = '0;
            end else begin
               step_cnt_d = step_cnt_q + WIDTH'(1);
            end
         end

         // A word completing on the handshake edge keeps valid high with new data.
         if (word_done) begin
            valid_d = 1'b1;
         end else if (handshake) begin
            valid_d = 1'b0;
         end

         // STALL marks a held word; leaving it costs one cycle before stepping resumes.
         fsm_d = (valid_q && !ready_in) ? STALL : RUN;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         fsm_q      <= IDLE;
         mode_q     <= MODE_FIB;
         lfsr_q     <= '0;
         seed_q     <= '0;
         step_cnt_q <= '0;
         period_q   <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         mode_q     <= mode_d;
         lfsr_q     <= lfsr_d;
         seed_q     <= seed_d;
         step_cnt_q <= step_cnt_d;
         period_q   <= period_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         wrap_q     <= wrap_d;
      end
   end

   assign q_out      = lfsr_q;
   assign data_out   = data_q;
   assign valid_out  = valid_q;
   assign wrap_out   = wrap_q;
   assign period_out = period_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed bench for lfsr_gen (WIDTH=4, TAPS=1100, OUT_W=4).
// A reference model predicts each step; completed words go into a queue
// and are popped when the DUT presents them on data_out.
module tb_lfsr_gen;
   import lfsr_pkg::*;

   localparam int unsigned     W  = 4;
   localparam int unsigned     OW = 4;
   localparam logic [W-1:0]    TP = 4'b1100;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  seed;
   logic          mode;
   logic          load;
   logic          en;
   logic          ready;
   logic [W-1:0]  q;
   logic [OW-1:0] data;
   logic          valid;
   logic          wrap;
   logic [W-1:0]  period;

   always #5 clk = ~clk;

   lfsr_gen #(
      .WIDTH (W),
      .TAPS  (TP),
      .OUT_W (OW)
   ) dut (
      .clk_in     (clk),
      .rst_n_in   (rst_n),
      .seed_in    (seed),
      .mode_in    (mode),
      .load_in    (load),
      .en_in      (en),
      .ready_in   (ready),
      .q_out      (q),
      .data_out   (data),
      .valid_out  (valid),
      .wrap_out   (wrap),
      .period_out (period)
   );

   int checks = 0;
   int errors = 0;

   logic [W-1:0]  m_state;
   logic [W-1:0]  m_seed;
   logic [OW-1:0] m_sh;
   logic          m_mode;
   int            m_bits;
   int            m_cnt;
   logic [W-1:0]  m_period;
   logic [OW-1:0] exp_q[$];

   function automatic logic [W-1:0] ref_next(input logic [W-1:0] s, input logic g);
      if (!g) return {s[W-2:0], ^(s & TP)};
      return (s >> 1) ^ (s[0] ? TP : 4'b0000);
   endfunction

   function automatic logic ref_bit(input logic [W-1:0] s, input logic g);
      return g ? s[0] : s[W-1];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [W-1:0] s, input logic g);
      load = 1'b1;
      seed = s;
      mode = g;
      tick();
      load = 1'b0;
      m_seed  = (s == '0) ? 4'b0001 : s;
      m_state = m_seed;
      m_sh    = '0;
      m_bits  = 0;
      m_cnt   = 0;
      m_mode  = g;
      exp_q.delete();
      check("load_q", 32'(q), 32'(m_state));
      check("load_valid", 32'(valid), 32'd0);
   endtask

   // One step the DUT is expected to take (valid low or ready high).
   task automatic run_step(input string tag);
      logic word_e;
      logic wrap_e;
      m_sh    = {m_sh[OW-2:0], ref_bit(m_state, m_mode)};
      m_state = ref_next(m_state, m_mode);
      m_bits++;
      word_e = (m_bits == OW);
      if (word_e) begin
         m_bits = 0;
         exp_q.push_back(m_sh);
      end
      m_cnt++;
      wrap_e = (m_state == m_seed);
      if (wrap_e) begin
         m_period = W'(m_cnt);
         m_cnt    = 0;
      end
      tick();
      check({tag, "_q"}, 32'(q), 32'(m_state));
      check({tag, "_valid"}, 32'(valid), 32'(word_e));
      check({tag, "_wrap"}, 32'(wrap), 32'(wrap_e));
      check({tag, "_period"}, 32'(period), 32'(m_period));
      if (valid === 1'b1 && exp_q.size() > 0)
         check({tag, "_data"}, 32'(data), 32'(exp_q.pop_front()));
   endtask

   initial begin
      logic [W-1:0]  seq_tbl [4];
      logic [W-1:0]  q_hold;
      logic [OW-1:0] d_hold;

      seq_tbl[0] = 4'b1011;
      seq_tbl[1] = 4'b0111;
      seq_tbl[2] = 4'b1111;
      seq_tbl[3] = 4'b1110;
      m_period   = '0;

      rst_n = 1'b0;
      seed  = '0;
      mode  = 1'b0;
      load  = 1'b0;
      en    = 1'b1;
      ready = 1'b1;
      tick();
      tick();
      check("rst_q", 32'(q), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_wrap", 32'(wrap), 32'd0);
      check("rst_period", 32'(period), 32'd0);
      rst_n = 1'b1;

      // IDLE: enable without a load does nothing.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_q", 32'(q), 32'd0);
      end

      // Fibonacci from 0101: known sequence, first word, full period.
      do_load(4'b0101, 1'b0);
      for (int i = 0; i < 4; i++) begin
         run_step("fib");
         check("fib_seq", 32'(q), 32'(seq_tbl[i]));
      end
      check("first_word", 32'(data), 32'(4'b0101));
      check("first_valid", 32'(valid), 32'd1);
      for (int i = 4; i < 15; i++) run_step("fib");
      check("wrap15", 32'(wrap), 32'd1);
      check("period15", 32'(period), 32'd15);

      // Back-pressure: the 16th step completes a word with ready low.
      ready = 1'b0;
      run_step("pre_stall");
      q_hold = q;
      d_hold = data;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_q", 32'(q), 32'(q_hold));
         check("stall_data", 32'(data), 32'(d_hold));
         check("stall_valid", 32'(valid), 32'd1);
         check("stall_fsm", 32'(dut.fsm_q), 32'(STALL));
      end
      ready = 1'b1;
      tick();
      check("accept_valid", 32'(valid), 32'd0);
      check("accept_q", 32'(q), 32'(q_hold));
      run_step("resume");

      // Load during STALL discards the pending word.
      ready = 1'b0;
      for (int i = 0; i < 3; i++) run_step("fill");
      tick();
      check("stall2_fsm", 32'(dut.fsm_q), 32'(STALL));
      do_load(4'b1001, 1'b0);
      ready = 1'b1;

      // Galois mode.
      do_load(4'b0101, 1'b1);
      run_step("gal");
      check("gal_first", 32'(q), 32'(4'b1110));
      for (int i = 1; i < 4; i++) run_step("gal");
      check("gal_word", 32'(data), 32'(4'b1011));
      for (int i = 4; i < 8; i++) run_step("gal");

      // Zero seed is replaced by 1; the state never reaches 0.
      do_load(4'b0000, 1'b0);
      check("zero_seed_q", 32'(q), 32'd1);
      for (int i = 0; i < 30; i++) begin
         run_step("zs");
         check("zs_nonzero", 32'(q != '0), 32'd1);
      end

      // Asynchronous reset mid-word.
      do_load(4'b0110, 1'b0);
      run_step("pre_rst");
      run_step("pre_rst");
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_q", 32'(q), 32'd0);
      check("arst_data", 32'(data), 32'd0);
      check("arst_valid", 32'(valid), 32'd0);
      check("arst_wrap", 32'(wrap), 32'd0);
      check("arst_period", 32'(period), 32'd0);
      m_period = '0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("post_rst_q", 32'(q), 32'd0);
         check("post_rst_valid", 32'(valid), 32'd0);
      end
      do_load(4'b0110, 1'b0);
      for (int i = 0; i < 4; i++) run_step("post_load");
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 16: LFSR state width, 3..32.
REQ-002 Parameter TAPS, default 16'hB400: feedback polynomial mask, WIDTH bits; TAPS[WIDTH-1] SHALL be 1, checked by an elaboration-time assertion.
REQ-003 Parameter OUT_W, default 8: bits per output word, 1..WIDTH.
REQ-004 Port clk_in, input, 1: single clock; all state on rising edge.
REQ-005 Port rst_n_in, input, 1: asynchronous, active-low reset.
REQ-006 Port seed_in, input, WIDTH: seed value, sampled on load.
REQ-007 Port mode_in, input, 1: 0 = Fibonacci, 1 = Galois, sampled on load.
REQ-008 Port load_in, input, 1: load seed and mode, restart generation.
REQ-009 Port en_in, input, 1: step enable.
REQ-010 Port ready_in, input, 1: downstream accepts data_out.
REQ-011 Port q_out, output, WIDTH: current LFSR state.
REQ-012 Port data_out, output, OUT_W: packed output word, first generated bit in the MSB.
REQ-013 Port valid_out, output, 1: data_out holds an unconsumed word.
REQ-014 Port wrap_out, output, 1: one-cycle pulse when the state returns to the loaded seed.
REQ-015 Port period_out, output, WIDTH: step count of the last completed period.

Function
REQ-016 FSM states: IDLE (no seed loaded), RUN (stepping allowed), STALL (valid_out=1 and ready_in=0).
REQ-017 load_in=1 at an edge in any state: state<=seed_in, or WIDTH'(1) if seed_in==0; mode latched; bit count, step count and valid_out cleared; next state RUN.
REQ-018 load_in has priority over every other input, including a pending word in STALL.
REQ-019 Step condition: state RUN, en_in=1, load_in=0, and NOT (valid_out=1 AND ready_in=0); one step per cycle, no latency beyond one clock.
REQ-020 Fibonacci step: fb = XOR-reduce(state AND TAPS); next = {state[WIDTH-2:0], fb}; out bit = state[WIDTH-1] before the step.
REQ-021 Galois step: next = (state >> 1) XOR (state[0] ? TAPS : 0); out bit = state[0] before the step.
REQ-022 Each step shifts the out bit into an OUT_W shift register; on the OUT_W-th bit, data_out is updated and valid_out is set at the same edge, and the bit count returns to 0.
REQ-023 A handshake occurs when valid_out=1 and ready_in=1; valid_out then clears unless a new word completes on the same edge, in which case it stays 1 with the new data.
REQ-024 While valid_out=1 and ready_in=0: LFSR, bit count and data_out frozen; FSM in STALL; on ready_in=1, return to RUN.
REQ-025 en_in=0: all state frozen; valid_out and data_out held.
REQ-026 The step counter increments per step; when the next state equals the loaded seed, wrap_out=1 for one cycle, period_out<=count+1, counter<=0.
REQ-027 The LFSR state SHALL never be zero after a load; in IDLE, steps are ignored and q_out stays 0.

Reset
REQ-028 rst_n_in=0 asynchronously forces IDLE, q_out=0, data_out=0, valid_out=0, wrap_out=0, period_out=0, and clears bit and step counters.
REQ-029 Reset mid-word or in STALL discards the partial or pending word; operation resumes only after load_in.

Structure
REQ-030 Package lfsr_pkg SHALL hold the FSM state enum (IDLE/RUN/STALL), the mode enum (MODE_FIB/MODE_GAL) and default tap constants for widths 4, 8, 16 and 32.
REQ-031 Sub-module lfsr_step (combinational next-state and out bit, parametrised by WIDTH and TAPS) SHALL be instantiated once.

Verification
REQ-032 WIDTH=4, TAPS=4'b1100, Fibonacci, seed 0101, en=1 -> q_out sequence 1011, 0111, 1111, 1110; wrap_out pulses after 15 steps with period_out=15.
REQ-033 Same configuration, OUT_W=4, ready_in=1 -> first data_out=4'b0101, valid_out high one cycle after the 4th step.
REQ-034 seed_in=0 with load -> q_out=0001; the state never reaches 0 over 30 cycles.
REQ-035 Word complete, ready_in=0 for 5 cycles -> q_out and data_out frozen, FSM in STALL; ready_in=1 -> word accepted, stepping resumes next cycle.
REQ-036 load_in asserted during STALL -> valid_out=0 and q_out=new seed at the next edge.
REQ-037 rst_n_in pulsed low between clock edges mid-word -> all outputs 0 immediately; q_out stays 0 with en_in=1 until load_in.
